ro_freq_meter: RTL and testbench
================================

RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 Parameter CNT_W, default 16, width of the edge count result.
REQ-002 Parameter GATE_CYCLES, default 1024, measurement window length in clock cycles (range 1..2^20).
REQ-003 Parameter SETTLE_CYCLES, default 16, oscillator warm-up cycles discarded before the window (range 0..2^16).
REQ-004 clock  input  1  single system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  request one measurement; sampled only in IDLE.
REQ-007 ro_en_o  output  1  enable for the ring oscillator (drives its R_in).
REQ-008 ro_in  input  1  oscillator output (its R_out); asynchronous to clock.
REQ-009 busy_o  output  1  high in SETTLE, MEASURE and DONE.
REQ-010 valid_o  output  1  result valid; high only in DONE.
REQ-011 ready_i  input  1  consumer accepts the result when valid_o && ready_i.
REQ-012 count_o  output  CNT_W  rising-edge count of the last completed window.
REQ-013 ovf_o  output  1  count saturated during the last window.

Function
REQ-014 ro_in SHALL pass through a 2-flop synchronizer followed by a third history flop; rise = sync2 & ~hist.
REQ-015 Measurable oscillator frequency SHALL be below fclk/2; faster inputs give aliased counts, which are not flagged.
REQ-016 FSM states SHALL be IDLE, SETTLE, MEASURE and DONE.
REQ-017 IDLE -> SETTLE on the edge where start_i=1; the window counter loads SETTLE_CYCLES and the edge counter clears to 0.
REQ-018 IDLE -> MEASURE directly when SETTLE_CYCLES=0.
REQ-019 ro_en_o SHALL be 1 exactly in SETTLE and MEASURE; it is a registered output, 0 otherwise.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, ignore rise, then go to MEASURE with the window counter loaded to GATE_CYCLES.
REQ-021 MEASURE SHALL last exactly GATE_CYCLES cycles; on each cycle with rise=1 the edge counter increments.
REQ-022 The edge counter SHALL saturate at 2^CNT_W-1, and the ovf flag sets on an increment attempted at saturation.
REQ-023 On the last MEASURE cycle, count_o and ovf_o SHALL load the final values (including a rise on that cycle), and the state goes to DONE.
REQ-024 Result latency SHALL be valid_o high exactly SETTLE_CYCLES+GATE_CYCLES+1 cycles after the start_i sampling edge.
REQ-025 DONE SHALL hold valid_o, count_o and ovf_o stable until valid_o && ready_i; the next state is then IDLE and valid_o drops the following cycle.
REQ-026 count_o and ovf_o SHALL retain their values in IDLE until the next result loads.
REQ-027 start_i SHALL be ignored in SETTLE, MEASURE and DONE, including the accept cycle; a new measurement needs start_i in IDLE.
REQ-028 ready_i SHALL have no effect outside DONE.
REQ-029 No result SHALL be produced for an interrupted measurement.

Reset
REQ-030 reset_n=0 SHALL immediately, without a clock, force: state=IDLE; ro_en_o=0; busy_o=0; valid_o=0; count_o=0; ovf_o=0; synchronizer/history flops=0; counters=0.
REQ-031 Reset asserted mid-SETTLE, mid-MEASURE or in DONE SHALL discard the measurement and gate the oscillator off at once.
REQ-032 After reset deassertion the block SHALL sit in IDLE until start_i.

Verification
REQ-033 Basic: SETTLE=16, GATE=64; ro_in square wave, period 4 clk; pulse start_i -> ro_en_o high for 80 cycles; valid_o at cycle 81; count_o=16 (+/-1 phase); ovf_o=0.
REQ-034 Held result: ready_i=0 for 20 cycles after valid_o -> valid_o, count_o and ovf_o unchanged; ready_i=1 -> valid_o=0 next cycle; busy_o=0.
REQ-035 Saturation: CNT_W=4, GATE=64, ro_in period 2 clk -> count_o=15; ovf_o=1.
REQ-036 Ignored start: start_i pulsed during MEASURE and on the accept cycle -> exactly one result; block returns to IDLE.
REQ-037 Reset mid-window: reset_n low at MEASURE cycle 30 -> ro_en_o=0, count_o=0 and valid_o=0 with no clock edge; after release, start_i gives a fresh full measurement.
REQ-038 Oscillator off: ro_in held 0 -> count_o=0; ovf_o=0; latency exactly SETTLE+GATE+1.

Source files
------------

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, discards a warm-up
// interval, then counts synchronised rising edges of ro_in over a fixed clock-cycle window.
`timescale 1ns/1ps
module ro_freq_meter #(
    parameter int CNT_W         = 16,
    parameter int GATE_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_i,
    output logic             ro_en_o,
    input  logic             ro_in,
    output logic             busy_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o,
    output logic [1:0]       state_o
);
    // Result handshake: a result transfers on any rising edge where
    // valid_o && ready_i; valid_o then holds with stable data until that edge.

    localparam int WIN_W = 21;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] edge_q, edge_d, edge_n;
    logic [CNT_W-1:0] count_q, count_d;
    logic             eovf_q, eovf_d, eovf_n;
    logic             rovf_q, rovf_d;
    logic             ro_en_q, ro_en_d;
    logic             sync1_q, sync2_q, hist_q;
    logic             rise;

    assign rise = sync2_q & ~hist_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= ro_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            edge_q  <= '0;
            eovf_q  <= 1'b0;
            count_q <= '0;
            rovf_q  <= 1'b0;
            ro_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            edge_q  <= edge_d;
            eovf_q  <= eovf_d;
            count_q <= count_d;
            rovf_q  <= rovf_d;
            ro_en_q <= ro_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        edge_d  = edge_q;
        eovf_d  = eovf_q;
        count_d = count_q;
        rovf_d  = rovf_q;
        // Saturating increment; the flag records an increment lost at full scale.
        edge_n  = edge_q;
        eovf_n  = eovf_q;
        if (rise) begin
            if (&edge_q) eovf_n = 1'b1;
            else         edge_n = edge_q + CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    edge_d = '0;
                    eovf_d = 1'b0;
                    if (SETTLE_CYCLES == 0) begin
                        state_d = MEASURE;
                        win_d   = WIN_W'(GATE_CYCLES);
                    end else begin
                        state_d = SETTLE;
                        win_d   = WIN_W'(SETTLE_CYCLES);
                    end
                end
            end
            SETTLE: begin
                if (win_q == WIN_W'(1)) begin
                    state_d = MEASURE;
                    win_d   = WIN_W'(GATE_CYCLES);
                end else begin
                    win_d = win_q - WIN_W'(1);
                end
            end
            MEASURE: begin
                edge_d = edge_n;
                eovf_d = eovf_n;
                if (win_q == WIN_W'(1)) begin
                    state_d = DONE;
                    win_d   = '0;
                    count_d = edge_n;
                    rovf_d  = eovf_n;
                end else begin
                    win_d = win_q - WIN_W'(1);
                end
            end
            DONE: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ro_en_d = (state_d == SETTLE) || (state_d == MEASURE);
    end

    assign ro_en_o = ro_en_q;
    assign busy_o  = (state_q != IDLE);
    assign valid_o = (state_q == DONE);
    assign count_o = count_q;
    assign ovf_o   = rovf_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: deterministic and random oscillator patterns, scoreboarded
// results with latency, held-result, ignored-start, saturation and async-reset cases.
`timescale 1ns/1ps
module tb_ro_freq_meter;
    localparam int A_S = 16;
    localparam int A_G = 64;
    localparam int B_S = 0;
    localparam int B_G = 64;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ro_in;
    logic        a_start, a_ready, a_ro_en, a_busy, a_valid, a_ovf;
    logic [15:0] a_count;
    logic [1:0]  a_state;
    logic        b_start, b_ready, b_ro_en, b_busy, b_valid, b_ovf;
    logic [3:0]  b_count;
    logic [1:0]  b_state;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          mode = 0;
    logic        rnd [0:16383];
    logic [31:0] a_exp_q[$];
    int          a_t_q[$];
    logic [31:0] b_exp_q[$];
    int          b_t_q[$];
    int          a_res = 0, b_res = 0, a_en_cnt = 0;
    logic        a_vprev = 1'b0, b_vprev = 1'b0;
    logic [31:0] a_last;

    ro_freq_meter #(.CNT_W(16), .GATE_CYCLES(A_G), .SETTLE_CYCLES(A_S)) dut_a (
        .clock(clock), .reset_n(reset_n), .start_i(a_start), .ro_en_o(a_ro_en),
        .ro_in(ro_in), .busy_o(a_busy), .valid_o(a_valid), .ready_i(a_ready),
        .count_o(a_count), .ovf_o(a_ovf), .state_o(a_state));

    ro_freq_meter #(.CNT_W(4), .GATE_CYCLES(B_G), .SETTLE_CYCLES(B_S)) dut_b (
        .clock(clock), .reset_n(reset_n), .start_i(b_start), .ro_en_o(b_ro_en),
        .ro_in(ro_in), .busy_o(b_busy), .valid_o(b_valid), .ready_i(b_ready),
        .count_o(b_count), .ovf_o(b_ovf), .state_o(b_state));

    // ---------------- clock / cycle index / oscillator ----------------
    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    function automatic logic pat(input int n);
        if (n < 0) return 1'b0;
        case (mode)
            0:       return 1'b0;
            1:       return ((n % 4) < 2);
            2:       return ((n % 2) == 1);
            default: return rnd[n % 16384];
        endcase
    endfunction

    initial begin
        ro_in = 1'b0;
        forever begin
            @(posedge clock);
            #1 ro_in = pat(cyc);
        end
    end

    // Expected {ovf, count}: rise seen in cycle c is ro_in(c-2) & ~ro_in(c-3),
    // counted over the window cycles that follow the settle interval.
    function automatic logic [31:0] model(input int s0, input int s, input int g, input int maxv);
        int   cnt;
        logic ov;
        cnt = 0;
        ov  = 1'b0;
        for (int c = s0 + s + 1; c <= s0 + s + g; c++) begin
            if (pat(c - 2) && !pat(c - 3)) begin
                if (cnt == maxv) ov = 1'b1;
                else             cnt = cnt + 1;
            end
        end
        return {15'b0, ov, cnt[15:0]};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    initial forever begin
        @(negedge clock);
        if (a_ro_en) a_en_cnt = a_en_cnt + 1;
        if (a_valid && !a_vprev) begin
            if (a_exp_q.size() == 0) begin
                check("a_unexpected_result", 32'd1, 32'd0);
            end else begin
                a_last = a_exp_q.pop_front();
                check("a_count", {16'b0, a_count}, {16'b0, a_last[15:0]});
                check("a_ovf", {31'b0, a_ovf}, {31'b0, a_last[16]});
                check("a_latency", cyc, a_t_q.pop_front());
                check("a_busy_done", {31'b0, a_busy}, 32'd1);
            end
            a_res = a_res + 1;
        end
        a_vprev = a_valid;
    end

    initial forever begin
        @(negedge clock);
        if (b_valid && !b_vprev) begin
            if (b_exp_q.size() == 0) begin
                check("b_unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = b_exp_q.pop_front();
                check("b_count", {28'b0, b_count}, {28'b0, e[3:0]});
                check("b_ovf", {31'b0, b_ovf}, {31'b0, e[16]});
                check("b_latency", cyc, b_t_q.pop_front());
            end
            b_res = b_res + 1;
        end
        b_vprev = b_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic start_a();
        int s0;
        @(posedge clock);
        #1 a_start = 1'b1;
        s0 = cyc;
        a_exp_q.push_back(model(s0, A_S, A_G, 65535));
        a_t_q.push_back(s0 + A_S + A_G + 1);
        @(posedge clock);
        #1 a_start = 1'b0;
    endtask

    task automatic start_b();
        int s0;
        @(posedge clock);
        #1 b_start = 1'b1;
        s0 = cyc;
        b_exp_q.push_back(model(s0, B_S, B_G, 15));
        b_t_q.push_back(s0 + B_S + B_G + 1);
        @(posedge clock);
        #1 b_start = 1'b0;
    endtask

    task automatic wait_a(input int bound);
        int n0, k;
        n0 = a_res;
        k  = 0;
        while (a_res == n0 && k < bound) begin
            @(posedge clock);
            k++;
        end
        #1;
        if (a_res == n0) check("a_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_b(input int bound);
        int n0, k;
        n0 = b_res;
        k  = 0;
        while (b_res == n0 && k < bound) begin
            @(posedge clock);
            k++;
        end
        #1;
        if (b_res == n0) check("b_timeout", 32'd0, 32'd1);
    endtask

    task automatic accept_a(input logic with_start);
        @(posedge clock);
        #1 a_ready = 1'b1;
        a_start = with_start;
        @(posedge clock);
        #1 a_ready = 1'b0;
        a_start = 1'b0;
        @(negedge clock);
        check("a_valid_after_accept", {31'b0, a_valid}, 32'd0);
        check("a_busy_after_accept", {31'b0, a_busy}, 32'd0);
        check("a_count_retained", {16'b0, a_count}, {16'b0, a_last[15:0]});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int r0;
        for (int i = 0; i < 16384; i++) rnd[i] = 1'($urandom_range(0, 1));
        reset_n = 1'b0;
        a_start = 1'b0; a_ready = 1'b0;
        b_start = 1'b0; b_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ro_en", {31'b0, a_ro_en}, 32'd0);
        check("rst_busy", {31'b0, a_busy}, 32'd0);
        check("rst_valid", {31'b0, a_valid}, 32'd0);
        check("rst_count", {16'b0, a_count}, 32'd0);
        check("rst_ovf", {31'b0, a_ovf}, 32'd0);
        check("rst_state", {30'b0, a_state}, 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("idle_after_reset", {31'b0, a_busy}, 32'd0);

        // Basic square wave, period 4, then a held result and accept with start ignored.
        mode = 1;
        repeat (6) @(posedge clock);
        a_en_cnt = 0;
        start_a();
        wait_a(200);
        check("a_ro_en_cycles", a_en_cnt, A_S + A_G);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("hold_valid", {31'b0, a_valid}, 32'd1);
            check("hold_count", {16'b0, a_count}, {16'b0, a_last[15:0]});
            check("hold_ovf", {31'b0, a_ovf}, {31'b0, a_last[16]});
            check("hold_ro_en", {31'b0, a_ro_en}, 32'd0);
        end
        accept_a(1'b1);
        repeat (10) @(negedge clock);
        check("start_on_accept_ignored", {31'b0, a_busy}, 32'd0);

        // Random oscillator; a start pulse in mid-window must not spawn a second result.
        mode = 3;
        repeat (6) @(posedge clock);
        r0 = a_res;
        start_a();
        repeat (A_S + 30) @(posedge clock);
        #1 a_start = 1'b1;
        @(posedge clock);
        #1 a_start = 1'b0;
        wait_a(200);
        accept_a(1'b0);
        repeat (150) @(negedge clock);
        check("one_result_only", a_res - r0, 32'd1);
        check("idle_after_ignored", {31'b0, a_busy}, 32'd0);

        // Asynchronous reset in the 30th window cycle.
        mode = 1;
        repeat (6) @(posedge clock);
        start_a();
        repeat (A_S + 30 - 1) @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_ro_en", {31'b0, a_ro_en}, 32'd0);
        check("midrst_count", {16'b0, a_count}, 32'd0);
        check("midrst_valid", {31'b0, a_valid}, 32'd0);
        check("midrst_busy", {31'b0, a_busy}, 32'd0);
        a_exp_q.delete();
        a_t_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (30) @(negedge clock);
        check("post_rst_idle", {31'b0, a_busy}, 32'd0);
        start_a();
        wait_a(200);
        accept_a(1'b0);

        // Oscillator off.
        mode = 0;
        repeat (6) @(posedge clock);
        start_a();
        wait_a(200);
        check("off_count", {16'b0, a_count}, 32'd0);
        accept_a(1'b0);

        // Saturation on the 4-bit, no-settle instance with a period-2 input.
        mode = 2;
        repeat (6) @(posedge clock);
        start_b();
        wait_b(200);
        check("sat_count", {28'b0, b_count}, 32'd15);
        check("sat_ovf", {31'b0, b_ovf}, 32'd1);
        @(posedge clock);
        #1 b_ready = 1'b1;
        @(posedge clock);
        #1 b_ready = 1'b0;
        @(negedge clock);
        check("b_valid_after_accept", {31'b0, b_valid}, 32'd0);

        // Random patterns with random consumer delay.
        for (int k = 0; k < 4; k++) begin
            mode = (k % 2 == 0) ? 3 : 1;
            repeat (6) @(posedge clock);
            start_a();
            wait_a(200);
            repeat ($urandom_range(0, 5)) @(posedge clock);
            accept_a(1'b0);
        end

        check("a_queue_drained", a_exp_q.size(), 32'd0);
        check("b_queue_drained", b_exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
